clocks_startup_seq: RTL



---
 rtl/clocks_startup_seq_pkg.sv | 36 +++
 rtl/clocks_startup_seq_if.sv | 31 +++
 rtl/clocks_startup_seq_sync2.sv | 27 ++
 rtl/clocks_startup_seq.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/clocks_startup_seq_pkg.sv
// Shared types and constants for the clock-domain startup sequencer.
package clocks_startup_seq_pkg;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_RELEASE   = 2'd1,
    ST_RUN       = 2'd2,
    ST_FAULT     = 2'd3
  } state_t;

  // Domain bit positions in LOCKED / RST_REQ
  localparam int unsigned DOM_WORD_GEN = 0;
  localparam int unsigned DOM_PKT_COMM = 1;
  localparam int unsigned DOM_CORE     = 2;
  localparam int unsigned DOM_CMP      = 3;

  // Default build parameters
  localparam int unsigned DEF_N_DOMAINS          = 4;
  localparam int unsigned DEF_LOCK_STABLE_CYCLES = 1024;
  localparam int unsigned DEF_STAGGER_CYCLES     = 16;
  localparam int unsigned DEF_FAULT_HOLD_CYCLES  = 64;
  localparam int unsigned DEF_LOSS_CNT_W         = 8;

  // Width of a counter that only ever needs to reach max(a,b,c)-1
  function automatic int unsigned cnt_width(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/clocks_startup_seq_if.sv
// Lock inputs and reset/status outputs of the startup sequencer.
interface clocks_startup_seq_if #(
  parameter int unsigned N_DOMAINS  = 4,
  parameter int unsigned LOSS_CNT_W = 8
);

  logic [N_DOMAINS-1:0]  locked;
  logic [N_DOMAINS-1:0]  rst_req;
  logic                  ready;
  logic [LOSS_CNT_W-1:0] loss_cnt;
  logic [N_DOMAINS-1:0]  lock_sync;

  // Clock-generation side: drives lock flags, observes sequencing
  modport master (
    output locked,
    input  rst_req,
    input  ready,
    input  loss_cnt,
    input  lock_sync
  );

  // Sequencer side
  modport slave (
    input  locked,
    output rst_req,
    output ready,
    output loss_cnt,
    output lock_sync
  );

endinterface

// File: rtl/clocks_startup_seq_sync2.sv
// Two-flop synchronizer for quasi-static flags crossing into clk; clears to 0 on rst.
module clocks_startup_seq_sync2 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Metastability stage followed by the stable output stage
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/clocks_startup_seq.sv
// Orders reset release of PLL-derived domains once all locks are stable,
// re-asserts every domain reset on lock loss and counts those losses.
module clocks_startup_seq
  import clocks_startup_seq_pkg::*;
#(
  parameter int unsigned N_DOMAINS          = DEF_N_DOMAINS,
  parameter int unsigned LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
  parameter int unsigned STAGGER_CYCLES     = DEF_STAGGER_CYCLES,
  parameter int unsigned FAULT_HOLD_CYCLES  = DEF_FAULT_HOLD_CYCLES,
  parameter int unsigned LOSS_CNT_W         = DEF_LOSS_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  clocks_startup_seq_if.slave  bus
);

  localparam int unsigned CNT_W = cnt_width(LOCK_STABLE_CYCLES, STAGGER_CYCLES,
                                            FAULT_HOLD_CYCLES);
  localparam int unsigned IDX_W = (N_DOMAINS > 1) ? $clog2(N_DOMAINS) : 1;

  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAG_LAST   = CNT_W'(STAGGER_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(FAULT_HOLD_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(N_DOMAINS - 1);

  logic [N_DOMAINS-1:0]  lock_sync;
  logic                  all_lock;
  logic                  lock_lost;

  state_t                state_q,   state_d;
  logic [CNT_W-1:0]      stable_q,  stable_d;
  logic [CNT_W-1:0]      stag_q,    stag_d;
  logic [CNT_W-1:0]      hold_q,    hold_d;
  logic [IDX_W-1:0]      idx_q,     idx_d;
  logic [IDX_W-1:0]      idx_next;
  logic [N_DOMAINS-1:0]  rst_req_q, rst_req_d;
  logic                  ready_q,   ready_d;
  logic [LOSS_CNT_W-1:0] loss_q,    loss_d;

  clocks_startup_seq_sync2 #(
    .WIDTH (N_DOMAINS)
  ) u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.locked),
    .q   (lock_sync)
  );

  assign all_lock  = &lock_sync;
  assign lock_lost = !all_lock && ((state_q == ST_RELEASE) || (state_q == ST_RUN));

  // Next-state and registered-output computation
  always_comb begin
    state_d   = state_q;
    stable_d  = stable_q;
    stag_d    = stag_q;
    hold_d    = hold_q;
    idx_d     = idx_q;
    idx_next  = idx_q + IDX_W'(1);
    rst_req_d = rst_req_q;
    ready_d   = ready_q;
    loss_d    = loss_q;

    unique case (state_q)
      ST_WAIT_LOCK: begin
        rst_req_d = '1;
        ready_d   = 1'b0;
        if (!all_lock) begin
          stable_d = '0;
        end else if (stable_q == STABLE_LAST) begin
          // First domain leaves reset on the same update that enters RELEASE
          stable_d     = '0;
          stag_d       = '0;
          idx_d        = '0;
          rst_req_d[0] = 1'b0;
          if (IDX_LAST == '0) begin
            state_d = ST_RUN;
            ready_d = 1'b1;
          end else begin
            state_d = ST_RELEASE;
          end
        end else begin
          stable_d = stable_q + CNT_W'(1);
        end
      end

      ST_RELEASE: begin
        if (stag_q == STAG_LAST) begin
          stag_d              = '0;
          idx_d               = idx_next;
          rst_req_d[idx_next] = 1'b0;
          if (idx_next == IDX_LAST) begin
            state_d = ST_RUN;
            ready_d = 1'b1;
          end
        end else begin
          stag_d = stag_q + CNT_W'(1);
        end
      end

      ST_RUN: begin
        rst_req_d = '0;
        ready_d   = 1'b1;
      end

      ST_FAULT: begin
        rst_req_d = '1;
        ready_d   = 1'b0;
        if (hold_q == HOLD_LAST) begin
          state_d  = ST_WAIT_LOCK;
          hold_d   = '0;
          stable_d = '0;
        end else begin
          hold_d = hold_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = ST_WAIT_LOCK;
      end
    endcase

    // Lock loss after release has begun overrides any pending release step
    if (lock_lost) begin
      state_d   = ST_FAULT;
      hold_d    = '0;
      stag_d    = '0;
      idx_d     = '0;
      rst_req_d = '1;
      ready_d   = 1'b0;
      if (loss_q != '1) begin
        loss_d = loss_q + LOSS_CNT_W'(1);
      end
    end
  end

  // State, counters and outputs register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_WAIT_LOCK;
      stable_q  <= '0;
      stag_q    <= '0;
      hold_q    <= '0;
      idx_q     <= '0;
      rst_req_q <= '1;
      ready_q   <= 1'b0;
      loss_q    <= '0;
    end else begin
      state_q   <= state_d;
      stable_q  <= stable_d;
      stag_q    <= stag_d;
      hold_q    <= hold_d;
      idx_q     <= idx_d;
      rst_req_q <= rst_req_d;
      ready_q   <= ready_d;
      loss_q    <= loss_d;
    end
  end

  assign bus.rst_req   = rst_req_q;
  assign bus.ready     = ready_q;
  assign bus.loss_cnt  = loss_q;
  assign bus.lock_sync = lock_sync;

endmodule
